// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and default-slave state type for the decode/mux slice.
// The optional error counter is enabled by defining AHB_DECODE_ERR_CNT_EN.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int unsigned ERR_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // NONSEQ and SEQ are the only transfer types that carry data.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_default_slave.sv
// Default slave: two-cycle ERROR response for accepted unmapped NONSEQ/SEQ transfers.
// With AHB_DECODE_ERR_CNT_EN defined, also counts error responses (saturating).
module ahb_lite_default_slave
    import ahb_lite_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic err_accept,
    output logic hready_c,
    output logic hresp_c
`ifdef AHB_DECODE_ERR_CNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
`endif
);

    ds_state_e state;
    ds_state_e state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ERR1 stalls the master, ERR2 completes the error and may accept a new transfer.
    always_comb begin
        state_next = state;
        hready_c   = 1'b1;
        hresp_c    = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (err_accept) begin
                    state_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                hready_c   = 1'b0;
                hresp_c    = HRESP_ERROR;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                hresp_c    = HRESP_ERROR;
                state_next = err_accept ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_next = DS_IDLE;
            end
        endcase
    end

`ifdef AHB_DECODE_ERR_CNT_EN
    logic err_start;
    assign err_start = (state_next == DS_ERR1) && (state != DS_ERR1);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_start && (err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: rtl/ahb_lite_decode_mux.sv
// AHB-Lite address decoder and slave response mux with built-in default slave.
// Define AHB_DECODE_ERR_CNT_EN to expose the 16-bit ERR_CNT output.
module ahb_lite_decode_mux
    import ahb_lite_pkg::*;
#(
    parameter int unsigned NUM_SLAVES  = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REGION_BITS = 4
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    output logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP
`ifdef AHB_DECODE_ERR_CNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0]         ERR_CNT
`endif
);

    logic [REGION_BITS-1:0] region;
    logic                   mapped;
    logic                   addr_low_unused;
    logic [NUM_SLAVES-1:0]  sel_q;
    logic                   def_q;
    logic                   err_accept;
    logic                   ds_hready;
    logic                   ds_hresp;

    assign region          = HADDR[ADDR_WIDTH-1 -: REGION_BITS];
    assign addr_low_unused = ^HADDR[ADDR_WIDTH-REGION_BITS-1:0];

    // Address-phase decode; regions beyond NUM_SLAVES leave every select low.
    always_comb begin
        HSEL = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (region == REGION_BITS'(i)) begin
                HSEL[i] = 1'b1;
            end
        end
    end

    assign mapped     = |HSEL;
    assign err_accept = HREADY && !mapped && is_active(HTRANS);

    // Data-phase select advances only when the current data phase completes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= '0;
            def_q <= 1'b0;
        end else if (HREADY) begin
            sel_q <= HSEL;
            def_q <= !mapped && is_active(HTRANS);
        end
    end

    ahb_lite_default_slave u_default_slave (
        .clk        (HCLK),
        .rst        (HRESET),
        .err_accept (err_accept),
        .hready_c   (ds_hready),
        .hresp_c    (ds_hresp)
`ifdef AHB_DECODE_ERR_CNT_EN
        ,
        .err_cnt    (ERR_CNT)
`endif
    );

    // Response mux: idle OKAY by default, selected slave, or default-slave error.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
        if (def_q) begin
            HRDATA = '0;
            HREADY = ds_hready;
            HRESP  = ds_hresp;
        end
    end

endmodule

// File: doc/ahb_lite_decode_mux.md
AHB_LITE_DECODE_MUX -- requirements
Module: ahb_lite_decode_mux

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_SLAVES, 4: mapped slaves, legal range 1..16.
- ADDR_WIDTH, 32: HADDR width.
- DATA_WIDTH, 32: read data width.
- REGION_BITS, 4: HADDR MSBs decoded as the region index.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- HCLK  in  1  single clock; all state updates on its rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HADDR  in  ADDR_WIDTH  master address-phase address.
- HTRANS  in  2  master transfer type.
- HSEL  out  NUM_SLAVES  one-hot address-phase slave select.
- HRDATA_S  in  NUM_SLAVES*DATA_WIDTH  slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- HREADYOUT_S  in  NUM_SLAVES  slave ready outputs.
- HRESP_S  in  NUM_SLAVES  slave responses.
- HRDATA  out  DATA_WIDTH  muxed read data to master.
- HREADY  out  1  muxed ready to master and to all slaves.
- HRESP  out  1  muxed response to master.

Function
REQ-003 HSEL[i] SHALL be combinational and equal 1 iff HADDR[ADDR_WIDTH-1 -: REGION_BITS] == i, for i < NUM_SLAVES; otherwise 0.
REQ-004 A region index >= NUM_SLAVES SHALL be unmapped, with all HSEL bits 0.
REQ-005 The data-phase select register (sel_q, one-hot plus a default flag) SHALL load from the address-phase decode only on a rising edge where HREADY=1; it SHALL hold while HREADY=0.
REQ-006 The default flag SHALL be set only when the loaded access is unmapped and HTRANS is NONSEQ (2'b10) or SEQ (2'b11).
REQ-007 While sel_q selects slave i, HRDATA, HREADY and HRESP SHALL equal slave i's HRDATA_S slice, HREADYOUT_S[i] and HRESP_S[i], with zero added latency.
REQ-008 When no slave is selected and the default flag is clear, outputs SHALL be HRDATA=0, HREADY=1, HRESP=0.
REQ-009 The default slave SHALL be an FSM with states DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-010 The FSM SHALL go DS_IDLE->DS_ERR1 when an unmapped NONSEQ/SEQ is accepted (HREADY=1).
REQ-011 DS_ERR1 SHALL drive HREADY=0, HRESP=1 and go unconditionally to DS_ERR2.
REQ-012 DS_ERR2 SHALL drive HREADY=1, HRESP=1; it SHALL go to DS_ERR1 if another unmapped NONSEQ/SEQ is accepted in that cycle, otherwise to DS_IDLE.
REQ-013 An unmapped IDLE (2'b00) or BUSY (2'b01) SHALL receive a zero-wait OKAY response.
REQ-014 A mapped transfer accepted during DS_ERR2 SHALL route its data phase to that slave in the next cycle.
REQ-015 In all default-slave states HRDATA SHALL be 0.

Reset
REQ-016 While HRESET=1 at a rising edge, sel_q SHALL clear to no selection with the default flag cleared, and the FSM SHALL enter DS_IDLE.
REQ-017 In the cycle after reset, outputs SHALL be HREADY=1, HRESP=0, HRDATA=0.
REQ-018 Reset asserted during DS_ERR1 or DS_ERR2 SHALL abort the error response with no residual state.

Configuration
REQ-019 When AHB_DECODE_ERR_CNT_EN is defined, an output ERR_CNT (16 bits) SHALL exist.
REQ-020 ERR_CNT SHALL increment once per DS_IDLE/DS_ERR2->DS_ERR1 transition, saturate at 16'hFFFF, and reset to 0.
REQ-021 When AHB_DECODE_ERR_CNT_EN is undefined, ERR_CNT and its counter SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-022 The shared package ahb_lite_pkg SHALL hold:
- HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
- HRESP encodings OKAY/ERROR.
- The default-slave state enum.
REQ-023 The default-slave FSM, with ERR_CNT when enabled, SHALL be the sub-module ahb_lite_default_slave.
REQ-024 Decode and mux logic SHALL remain in ahb_lite_decode_mux.

Verification
REQ-025 Reset then idle bus: the bench SHALL check HREADY=1, HRESP=0, HRDATA=0 and HSEL=4'b0000.
REQ-026 NONSEQ read HADDR=32'h2000_0010 with slave 2 returning HRDATA_S slice 32'hCAFE_0002 and zero wait: the bench SHALL check HSEL=4'b0100 in the address phase and HRDATA=32'hCAFE_0002, HREADY=1, HRESP=0 next cycle.
REQ-027 Slave 1 holds HREADYOUT_S[1]=0 for 3 cycles while HADDR changes to 32'h3000_0000: the bench SHALL check sel_q stays on slave 1, HREADY=0 for 3 cycles, and slave 3 is selected only after HREADY=1.
REQ-028 NONSEQ HADDR=32'h5000_0000 (NUM_SLAVES=4): the bench SHALL check HSEL=0, then HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then OKAY; with the macro, ERR_CNT=1.
REQ-029 Back-to-back unmapped NONSEQ at 32'h7000_0000 issued in DS_ERR2: the bench SHALL check a second two-cycle ERROR follows immediately; with the macro, ERR_CNT=2.
REQ-030 Unmapped IDLE HTRANS=2'b00, and separately HRESET pulsed in DS_ERR1: the bench SHALL check a zero-wait OKAY and, after the reset pulse, HREADY=1/HRESP=0.
